// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: a DEPTH-entry FIFO of {data, ctrl} records with
// valid/ready on both sides. Control bits read as zero whenever no record is presented.
module pipe_stage_buf #(
    parameter int DATA_W = 48,
    parameter int CTRL_W = 9,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } rec_t;

    rec_t [DEPTH-1:0] slots;
    rec_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Readiness comes only from registered occupancy: a full buffer never
    // accepts in the same cycle it drains.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign head      = slots[rd_ptr];
    assign out_data  = head.data;
    assign out_ctrl  = out_valid ? head.ctrl : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push)
                wr_ptr <= wrap_inc(wr_ptr);
            if (pop)
                rd_ptr <= wrap_inc(rd_ptr);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Slots are cleared on reset so out_data reads zero straight after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slots <= '0;
        else if (push)
            slots[wr_ptr] <= '{data: in_data, ctrl: in_ctrl};
    end

endmodule
